// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] UART_DATA_OFS = 2'b00;
    localparam logic [1:0] UART_STAT_OFS = 2'b10;

    localparam int BUSY  = 0;
    localparam int FULL  = 1;
    localparam int EMPTY = 2;
    localparam int OVF   = 3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the CPU write port and the serialiser.
// Pointers carry one extra wrap bit so full/empty come from a plain compare.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until pushed
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_io.sv
// UART transmitter IO peripheral: register decode, baud counter and frame FSM.
// Optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_io
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 23_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        uartcs,
    input  logic        uartwrite,
    input  logic        uartread,
    input  logic [1:0]  uartaddr,
    input  logic [15:0] uartwdata,
    output logic [15:0] uartrdata,
    output logic        txd
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    tx_state_t     state;
    tx_state_t     state_nxt;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          ovf;
    logic          busy;
    logic          bit_end;
    logic          pop;
    logic          push_req;
    logic          stat_rd;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [3:0]    status;
    logic          unused_wdata;
`ifdef UART_TX_PARITY_EN
    logic          par;
`endif

    assign push_req     = uartcs & uartwrite & (uartaddr == UART_DATA_OFS);
    assign stat_rd      = uartcs & uartread & (uartaddr == UART_STAT_OFS);
    assign bit_end      = (baud_cnt == CW'(DIV - 1));
    assign busy         = (state != ST_IDLE);
    assign unused_wdata = ^uartwdata[15:8];

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .wdata (uartwdata[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state, FIFO pop and line level
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        txd       = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                txd = 1'b0;
                if (bit_end) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                txd = shift[0];
                if (bit_end && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
            ST_PARITY: begin
`ifdef UART_TX_PARITY_EN
                txd = par;
                if (bit_end) state_nxt = ST_STOP;
`else
                state_nxt = ST_IDLE;
`endif
            end
            ST_STOP: begin
                if (bit_end) begin
                    // Chain the next queued byte straight into a start bit.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Baud counter, bit counter and shift register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else if (pop) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
            par      <= ^fifo_rdata;
`endif
        end else if (state == ST_IDLE) begin
            baud_cnt <= '0;
        end else if (bit_end) begin
            baud_cnt <= '0;
            if (state == ST_DATA) begin
                shift   <= shift >> 1;
                bit_cnt <= bit_cnt + 3'd1;
            end
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    // Sticky overflow; a new overflow wins over the read-to-clear
    always_ff @(posedge clock or posedge rst) begin
        if (rst)                              ovf <= 1'b0;
        else if (push_req & fifo_full & ~pop) ovf <= 1'b1;
        else if (stat_rd)                     ovf <= 1'b0;
    end

    // Combinational read mux for the MemOrIO read path
    always_comb begin
        status        = '0;
        status[BUSY]  = busy;
        status[FULL]  = fifo_full;
        status[EMPTY] = fifo_empty;
        status[OVF]   = ovf;
        uartrdata     = stat_rd ? {12'b0, status} : 16'h0000;
    end

endmodule

// File: doc/uart_tx_io.md
# uart_tx_io

Memory-mapped UART transmitter peripheral for the single-cycle CPU's IO space. It is the outbound counterpart of the UART receive/programming path that runs from the UART clock. The CPU writes bytes through the MemOrIO decode, using the same cs/read/write/addr handshake as the switch and LED drivers. Bytes are queued in a small FIFO and serialised 8N1 (optionally 8E1) on a single TXD pin. The CPU polls a status register to pace its writes.

## Interface
Parameters:
- CLK_HZ, 23_000_000, frequency of `clock` in Hz
- BAUD, 115_200, line rate in bit/s; DIV = CLK_HZ/BAUD (integer division), DIV ≥ 2
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥ 2

Ports:
- clock  in  1  system clock; all state is updated on its rising edge
- rst  in  1  asynchronous, active-high reset
- uartcs  in  1  chip select from MemOrIO address decode
- uartwrite  in  1  CPU IO write strobe
- uartread  in  1  CPU IO read strobe
- uartaddr  in  2  register offset: 2'b00 = DATA, 2'b10 = STATUS
- uartwdata  in  16  write data; only [7:0] is used
- uartrdata  out  16  read data; combinational
- txd  out  1  serial output; idles high

## Operation
- **Push to FIFO.** A cycle with uartcs & uartwrite & addr==00 pushes uartwdata[7:0] into the FIFO at the clock edge.
  - If the FIFO is full, the byte is dropped and the sticky `ovf` flag is set.
  - Writes to any other offset are ignored.
- **STATUS read.** uartcs & uartread & addr==10 drives uartrdata = {12'b0, ovf, empty, full, busy}.
  - Any other read returns 16'h0000.
  - `ovf` clears on the clock edge that ends a STATUS read. If an overflow occurs in that same cycle, set wins.
- **Transmit FSM.** States are IDLE, START, DATA, PARITY (macro only) and STOP. A baud counter counts 0..DIV-1, and each state lasts exactly DIV cycles.
  - IDLE, FIFO not empty: pop the FIFO into the shift register, go to START, load bit_cnt = 0.
  - START: txd = 0, then go to DATA.
  - DATA: txd = shift[0], LSB first. After each bit, shift right and increment bit_cnt. After bit 7, go to STOP (or to PARITY with the macro).
  - STOP: txd = 1. At the end of STOP, if the FIFO is not empty, pop and go straight to START, with no idle gap. Otherwise go to IDLE.
- `busy` = (state != IDLE).
- **FIFO pointers.** Read and write pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. `full` and `empty` come from pointer comparison.
  - A push and a pop in the same cycle are both accepted, including when the FIFO is full; the count is unchanged.
  - A pop is only issued when the FIFO is non-empty. There is no bypass from the write port to the shifter.
- **Reset values:** txd = 1, uartrdata = 0, FIFO empty, ovf = 0, state IDLE, counters 0. Asserting reset mid-frame truncates the frame immediately: txd goes high asynchronously and any queued bytes are lost.

## Timing
- If a DATA write hits edge N with the FSM idle, the pop occurs at edge N+1 and txd falls after edge N+1.
- Frame length is 10·DIV cycles (11·DIV with parity), measured from the falling txd edge to the end of STOP.
- Back-to-back frames: the next start bit begins on the cycle right after the last stop cycle.
- STATUS reflects the registered state: `full`, `empty` and `ovf` update the cycle after the causing edge.
- uartrdata is combinational in the select/read/addr inputs. It is valid within the same cycle, as the MemOrIO read path requires.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state of DIV cycles sits between DATA and STOP. It transmits even parity (XOR of the 8 data bits), giving 8E1 frames of 11·DIV cycles.
- Undefined: no PARITY state and no parity logic; frames are 8N1, 10·DIV cycles.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum (including PARITY, always declared);
  - register offsets UART_DATA_OFS = 2'b00 and UART_STAT_OFS = 2'b10;
  - STATUS bit indices BUSY = 0, FULL = 1, EMPTY = 2, OVF = 3.
- Sub-module `uart_tx_fifo`: a synchronous FIFO with push/pop/full/empty and FIFO_DEPTH parameter. `uart_tx_io` contains only the register decode, the baud counter and the FSM.

## Test plan
- **Single byte.** CLK_HZ = 8, BAUD = 1 (DIV = 8). Write 0x55 → txd low for 8 cycles, then 1,0,1,0,1,0,1,0 at 8 cycles each, then high for 8 cycles. busy = 1 for 80 cycles, then 0.
- **Back-to-back.** Write 0xA5 and 0x0F on consecutive cycles → two 80-cycle frames with txd high only during the stop bits. empty = 1 once the second pop occurs.
- **Overflow.** FIFO_DEPTH = 4; write 0x00..0x05 on 6 consecutive cycles.
  - 0x00 is popped at once, 0x01..0x04 fill the FIFO, and 0x05 is dropped.
  - STATUS reads 0x000B while the first frame is in progress (busy, full, ovf). The next STATUS read shows ovf = 0.
  - Exactly 5 frames (0x00..0x04) are transmitted.
- **Reset mid-frame.** Assert rst during DATA bit 3 of 0xFF with 3 bytes queued → txd = 1 immediately and STATUS = 0x0004 after reset. No further frames are sent.
- **Illegal access.** A read of offset 01, or with uartcs = 0, returns 0x0000. A write to offset 10 leaves the FIFO unchanged.
- **Parity.** With UART_TX_PARITY_EN and 0x07: the parity bit is 1 and the frame lasts 88 cycles. With 0x03: the parity bit is 0.
